// File: rtl/alu_divider_seq.sv
// Sequential restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Produces one quotient bit per clock. Divide-by-zero and signed overflow finish in a single cycle.
module alu_divider_seq #(
    parameter int l = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [l-1:0] dividend,
    input  logic [l-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [l-1:0] quotient,
    output logic [l-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(l + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [l-1:0]  rem_q;
    logic [l-1:0]  quo_q;
    logic [l-1:0]  dvs_mag;
    logic          neg_q;
    logic          neg_r;

    logic          accept;
    logic          a_neg;
    logic          b_neg;
    logic [l-1:0]  a_mag;
    logic [l-1:0]  b_mag;
    logic          is_zero;
    logic          is_ovf;

    logic [l:0]    shifted;
    logic [l:0]    trial;
    logic [l-1:0]  rem_nx;
    logic [l-1:0]  quo_nx;
    logic [l-1:0]  q_fin;
    logic [l-1:0]  r_fin;

    // Operand decode, only meaningful in the cycle start is accepted.
    assign accept  = start && (state != CALC);
    assign a_neg   = is_signed & dividend[l-1];
    assign b_neg   = is_signed & divisor[l-1];
    assign a_mag   = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag   = b_neg ? (~divisor + 1'b1) : divisor;
    assign is_zero = (divisor == '0);
    assign is_ovf  = is_signed && (dividend == {1'b1, {(l-1){1'b0}}}) && (divisor == '1);

    // One restoring step: the dividend magnitude shifts out of quo_q into rem_q
    // while quotient bits shift in from the bottom.
    assign shifted = {rem_q, quo_q[l-1]};
    assign trial   = shifted - {1'b0, dvs_mag};
    assign rem_nx  = trial[l] ? shifted[l-1:0] : trial[l-1:0];
    assign quo_nx  = {quo_q[l-2:0], ~trial[l]};
    assign q_fin   = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    assign r_fin   = neg_r ? (~rem_nx + 1'b1) : rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (accept) begin
                        if (is_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (is_ovf) begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvs_mag <= b_mag;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            count   <= CW'(l);
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    count <= count - 1'b1;
                    // Last step: publish the signed-corrected results on the DONE entry edge.
                    if (count == CW'(1)) begin
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
